// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC / stall / flush controller for the fetch stage.
// Picks sequential fetch, branch or jump redirect; inserts load-use bubbles;
// holds fetch while imem is not ready and flags a sticky fetch timeout.
// Optional build macro PC_SEQ_PERF_EN adds stall_cnt_o / flush_cnt_o counters.
module pc_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_tgt_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic [31:0] pc_next_o,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pend_v_q, pend_v_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;

  logic               hazard;
  logic               redir;
  logic [31:0]        tgt;

  // Load-use hazard and redirect target decode (jump wins over branch)
  always_comb begin
    hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
             ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    redir  = jump_i || branch_i;
    tgt    = jump_i ? jump_tgt_i : branch_tgt_i;
  end

  // State and control registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= 32'd0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state, pending redirect capture and wait counter
  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d    = ST_IDLE;
          pend_v_d   = 1'b0;
          wait_cnt_d = '0;
        end else if (!imem_ack_i) begin
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_W'(1);
          // Remember a redirect seen while fetch stalls so it is not lost
          if (redir && !hazard) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = tgt;
          end
        end else if (hazard) begin
          state_d = ST_RUN;
        end else if (pend_v_q) begin
          pend_v_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!start_i) begin
          state_d    = ST_IDLE;
          pend_v_d   = 1'b0;
          wait_cnt_d = '0;
        end else if (imem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_W'(WAIT_MAX)) begin
            timeout_d = 1'b1;
            state_d   = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs from state and inputs
  always_comb begin
    imem_req_o    = 1'b0;
    pc_stall_o    = 1'b1;
    ifid_stall_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pc_next_o     = RESET_PC;
    unique case (state_q)
      ST_RUN: begin
        imem_req_o = 1'b1;
        if (!imem_ack_i) begin
          pc_next_o = pc_i;
        end else if (hazard) begin
          idex_bubble_o = 1'b1;
          pc_next_o     = pc_i;
        end else begin
          pc_stall_o   = 1'b0;
          ifid_stall_o = 1'b0;
          if (pend_v_q) begin
            pc_next_o    = pend_tgt_q;
            ifid_flush_o = 1'b1;
          end else if (redir) begin
            pc_next_o    = tgt;
            ifid_flush_o = 1'b1;
          end else begin
            pc_next_o = pc_i + 32'd4;
          end
        end
      end
      ST_WAIT: begin
        imem_req_o = 1'b1;
        pc_next_o  = pc_i;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

`ifdef PC_SEQ_PERF_EN
  // Stall and flush event counters, free-running with wrap
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (pc_stall_o && ((state_q == ST_RUN) || (state_q == ST_WAIT)))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (ifid_flush_o)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a RUN-state vector table plus
// hand-written sequences for pending redirect, timeout and async reset.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        branch_i;
  logic [31:0] branch_tgt_i;
  logic        jump_i;
  logic [31:0] jump_tgt_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic [4:0]  ifid_rs_i;
  logic [4:0]  ifid_rt_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] pc_next_o;
  logic        pc_stall_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        timeout_o;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.WAIT_MAX(15), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .branch_i(branch_i), .branch_tgt_i(branch_tgt_i),
    .jump_i(jump_i), .jump_tgt_i(jump_tgt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .imem_ack_i(imem_ack_i), .imem_req_o(imem_req_o),
    .pc_next_o(pc_next_o), .pc_stall_o(pc_stall_o),
    .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .timeout_o(timeout_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [31:0] btgt;
    logic        jmp;
    logic [31:0] jtgt;
    logic        memrd;
    logic [4:0]  xrt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_next;
    logic [3:0]  exp_flags;  // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
  } vec_t;

  function automatic vec_t mkv(input logic [31:0] pc, input logic br,
                               input logic [31:0] btgt, input logic jmp,
                               input logic [31:0] jtgt, input logic memrd,
                               input logic [4:0] xrt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [31:0] en,
                               input logic [3:0] ef);
    vec_t v;
    v.pc = pc; v.br = br; v.btgt = btgt; v.jmp = jmp; v.jtgt = jtgt;
    v.memrd = memrd; v.xrt = xrt; v.rs = rs; v.rt = rt;
    v.exp_next = en; v.exp_flags = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reset-value output bundle: {req, pc_stall, ifid_stall, flush, bubble}
  task automatic check_reset_outs(input string name);
    check({name, " outs"}, 32'({imem_req_o, pc_stall_o, ifid_stall_o,
                                ifid_flush_o, idex_bubble_o}), 32'b01100);
    check({name, " pc_next"}, pc_next_o, 32'h0);
    check({name, " state"}, 32'(state_o), 32'd0);
    check({name, " timeout"}, 32'(timeout_o), 32'd0);
  endtask

  task automatic clear_ins();
    branch_i = 1'b0; branch_tgt_i = 32'h0; jump_i = 1'b0; jump_tgt_i = 32'h0;
    idex_memread_i = 1'b0; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
  endtask

  vec_t vecs[9];
  int   wait_cycles;

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_i = 32'h0; imem_ack_i = 1'b0;
    clear_ins();

    vecs[0] = mkv(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 4'b0000);
    vecs[1] = mkv(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0000);
    vecs[2] = mkv(32'h40, 1, 32'h300, 0, 0, 1, 5, 5, 0, 32'h40, 4'b1101);
    vecs[3] = mkv(32'h40, 1, 32'h300, 0, 0, 1, 0, 5, 0, 32'h300, 4'b0010);
    vecs[4] = mkv(32'h80, 0, 0, 0, 0, 1, 7, 1, 7, 32'h80, 4'b1101);
    vecs[5] = mkv(32'h80, 0, 0, 0, 0, 0, 7, 7, 7, 32'h84, 4'b0000);
    vecs[6] = mkv(32'h1000, 1, 32'h300, 1, 32'h2000, 0, 0, 0, 0, 32'h2000, 4'b0010);
    vecs[7] = mkv(32'h1000, 0, 0, 1, 32'h3004, 0, 0, 0, 0, 32'h3004, 4'b0010);
    vecs[8] = mkv(32'h10, 1, 32'h600, 0, 0, 1, 3, 4, 5, 32'h600, 4'b0010);

    // Reset state
    #3;
    check_reset_outs("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1 check("idle hold state", 32'(state_o), 32'd0);

    // Start: IDLE outputs this cycle, RUN after the edge
    start_i = 1'b1; imem_ack_i = 1'b1; pc_i = 32'h100;
    #1 check_reset_outs("idle start");

    // RUN vector table
    foreach (vecs[i]) begin
      @(negedge clk_i);
      pc_i = vecs[i].pc; branch_i = vecs[i].br; branch_tgt_i = vecs[i].btgt;
      jump_i = vecs[i].jmp; jump_tgt_i = vecs[i].jtgt;
      idex_memread_i = vecs[i].memrd; idex_rt_i = vecs[i].xrt;
      ifid_rs_i = vecs[i].rs; ifid_rt_i = vecs[i].rt;
      #1;
      check($sformatf("vec%0d pc_next", i), pc_next_o, vecs[i].exp_next);
      check($sformatf("vec%0d flags", i),
            32'({pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o}),
            32'(vecs[i].exp_flags));
      check($sformatf("vec%0d req/state", i), 32'({imem_req_o, state_o}), 32'b101);
    end

    // Branch during imem stall: pending redirect applied after ack
    @(negedge clk_i);
    clear_ins(); pc_i = 32'h500; branch_i = 1'b1; branch_tgt_i = 32'h200;
    imem_ack_i = 1'b0;
    #1 check("pend run noack", 32'({state_o, pc_stall_o, ifid_stall_o, ifid_flush_o}), 32'b01110);
    check("pend run pc_next", pc_next_o, 32'h500);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      branch_i = 1'b0; branch_tgt_i = 32'h0;
      imem_ack_i = (k == 2);
      #1 check($sformatf("pend wait%0d", k),
               32'({state_o, imem_req_o, pc_stall_o, ifid_stall_o, ifid_flush_o}),
               32'b101110);
      check($sformatf("pend wait%0d pc_next", k), pc_next_o, 32'h500);
    end
    @(negedge clk_i);
    #1 check("pend apply", 32'({state_o, pc_stall_o, ifid_flush_o}), 32'b0101);
    check("pend apply pc_next", pc_next_o, 32'h200);
    @(negedge clk_i);
    pc_i = 32'h200;
    #1 check("pend once flush", 32'(ifid_flush_o), 32'd0);
    check("pend once pc_next", pc_next_o, 32'h204);

    // Fetch timeout after WAIT_MAX wait cycles
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    wait_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      #1;
      if (state_o == 2'd2) wait_cycles++;
      else break;
    end
    check("timeout wait cycles", 32'(wait_cycles), 32'd15);
    check("timeout state", 32'(state_o), 32'd3);
    check("timeout flag/req", 32'({timeout_o, imem_req_o, pc_stall_o, ifid_stall_o}), 32'b1011);
    check("halt pc_next", pc_next_o, 32'h0);
    imem_ack_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1 check("halt sticky", 32'({state_o, timeout_o}), 32'b111);
    rst_i = 1'b0;
    #1 check_reset_outs("halt reset");

    // Async reset in the middle of WAIT
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b1; pc_i = 32'h900;
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 check("midwait state", 32'(state_o), 32'd2);
    #1 rst_i = 1'b0;
    #1 check_reset_outs("midwait reset");

    // start_i low in WAIT drops the pending redirect
    @(negedge clk_i);
    rst_i = 1'b1; imem_ack_i = 1'b1; pc_i = 32'hA00;
    @(negedge clk_i);
    imem_ack_i = 1'b0; branch_i = 1'b1; branch_tgt_i = 32'h700;
    @(negedge clk_i);
    clear_ins(); start_i = 1'b0;
    #1 check("stop in wait outs", 32'({state_o, pc_stall_o, imem_req_o}), 32'b1011);
    @(negedge clk_i);
    #1 check("stop idle", 32'(state_o), 32'd0);
    start_i = 1'b1; imem_ack_i = 1'b1;
    @(negedge clk_i);
    #1 check("no stale pend", 32'({ifid_flush_o, state_o}), 32'b001);
    check("no stale pend pc_next", pc_next_o, 32'hA04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block driving the PC register's next-PC and stall inputs and the IF/ID pipeline register controls in the pipelined CPU.
- Selects between sequential fetch, branch and jump redirects; inserts load-use stalls; holds fetch while instruction memory is not ready.
- Flags a fetch timeout.
- Purely a controller: the PC register itself stays a separate block.

Parameters:
- WAIT_MAX, 15: maximum consecutive not-ready imem cycles before timeout (1..255).
- RESET_PC, 32'h0000_0000: value of pc_next_o while IDLE or HALT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  run enable; low returns FSM to IDLE
- pc_i  in  32  current PC from PC register
- branch_i  in  1  taken branch resolved in ID
- branch_tgt_i  in  32  branch target
- jump_i  in  1  jump in ID
- jump_tgt_i  in  32  jump target
- idex_memread_i  in  1  ID/EX holds a load
- idex_rt_i  in  5  load destination register
- ifid_rs_i  in  5  ID source rs
- ifid_rt_i  in  5  ID source rt
- imem_ack_i  in  1  instruction memory returns data this cycle
- imem_req_o  out  1  fetch request
- pc_next_o  out  32  next PC to PC register
- pc_stall_o  out  1  hold PC register
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  zero IF/ID (bubble)
- idex_bubble_o  out  1  zero ID/EX control
- timeout_o  out  1  sticky fetch timeout
- state_o  out  2  FSM state: IDLE=0, RUN=1, WAIT=2, HALT=3

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, pend_v=0, pend_tgt=0, wait_cnt=0, timeout_o=0.
- Reset output values: imem_req_o=0, pc_stall_o=1, ifid_stall_o=1, ifid_flush_o=0, idex_bubble_o=0, pc_next_o=RESET_PC.
- Outputs are combinational from state plus inputs. All registers update on clk_i rising edge.
- Definitions:
  - hazard = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i)
  - redir = jump_i | branch_i
  - tgt = jump_i ? jump_tgt_i : branch_tgt_i (jump wins if both asserted)
- IDLE:
  - Outputs as at reset.
  - start_i=1 -> RUN next cycle.
- RUN (imem_req_o=1), evaluated in priority order:
  - imem_ack_i=0: pc_stall_o=1, ifid_stall_o=1, pc_next_o=pc_i; -> WAIT, wait_cnt=1. If redir & ~hazard, capture pend_tgt=tgt, pend_v=1.
  - hazard: pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1, pc_next_o=pc_i. A redir in the same cycle is ignored; the branch re-resolves next cycle.
  - pend_v: pc_next_o=pend_tgt, ifid_flush_o=1; clear pend_v.
  - redir: pc_next_o=tgt, ifid_flush_o=1.
  - otherwise: pc_next_o=pc_i+4, modulo 2^32 (wraps to 0).
- WAIT (imem_req_o=1):
  - pc_stall_o=1, ifid_stall_o=1, pc_next_o=pc_i.
  - imem_ack_i=1 -> RUN, wait_cnt=0.
  - else wait_cnt+1; if wait_cnt==WAIT_MAX, set timeout_o=1 and go to HALT.
- HALT:
  - imem_req_o=0, pc_stall_o=1, ifid_stall_o=1.
  - Exits only via reset.
- start_i=0 in RUN or WAIT:
  - -> IDLE next cycle; pend_v and wait_cnt cleared.
  - Outputs that cycle follow the current state.
- Latency: redirect takes effect in the same cycle as redir (PC loads tgt at the next edge). A pending redirect applies on the first RUN cycle with ack.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - stall_cnt_o increments each cycle pc_stall_o=1 in RUN or WAIT.
  - flush_cnt_o increments each cycle ifid_flush_o=1.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset low, then start_i=1 with ack=1 and pc_i=0x100 -> state_o=1; pc_next_o=0x104; all stall/flush outputs 0.
- pc_i=0xFFFFFFFC in RUN with ack=1 -> pc_next_o=0x0.
- idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, branch_i=1 -> pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1, ifid_flush_o=0, pc_next_o=pc_i. The same case with idex_rt_i=0 -> no stall.
- branch_i=1, branch_tgt_i=0x200, ack=0 for 3 cycles, then ack=1 -> 3 stall cycles in WAIT, then pc_next_o=0x200 with ifid_flush_o=1 for exactly one cycle.
- ack held 0 with WAIT_MAX=15 -> timeout_o=1 and state_o=3 after 15 WAIT cycles; imem_req_o=0; recovery only by rst_i low, after which state_o=0 and timeout_o=0.
- rst_i asserted low mid-WAIT -> all outputs take reset values immediately, without waiting for a clock edge.
